// File: rtl/ser_bus_arbiter_if.sv
// Requester-side and SER-side signals of the serializer egress arbiter.
// The arbiter uses the master modport; the requesters and SER use the slave modport.
interface ser_bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_lock;
    logic [NREQ*15-1:0]  req_pAdr;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ*4-1:0]   req_dest;
    logic [NREQ*4-1:0]   req_return;
    logic [NREQ-1:0]     req_rw;
    logic [NREQ*16-1:0]  req_size;
    logic [NREQ-1:0]     req_read;

    logic [2:0]          grant_id;
    logic                valid_s;
    logic [14:0]         pAdr_s;
    logic [127:0]        data_s;
    logic [3:0]          dest_s;
    logic [3:0]          return_s;
    logic                rw_s;
    logic [15:0]         size_s;
    logic                full_block_s;
    logic                free_block_s;

    modport master (
        input  req_valid, req_lock, req_pAdr, req_data, req_dest, req_return, req_rw, req_size,
        input  full_block_s, free_block_s,
        output req_read, grant_id, valid_s, pAdr_s, data_s, dest_s, return_s, rw_s, size_s
    );

    modport slave (
        output req_valid, req_lock, req_pAdr, req_data, req_dest, req_return, req_rw, req_size,
        output full_block_s, free_block_s,
        input  req_read, grant_id, valid_s, pAdr_s, data_s, dest_s, return_s, rw_s, size_s
    );
endinterface

// File: rtl/ser_bus_arbiter.sv
// Round-robin arbiter sharing the SER egress port among NREQ requesters, with a
// registered one-entry output stage and optional locked bursts for multi-packet transfers.
module ser_bus_arbiter #(
    parameter int NREQ         = 4,
    parameter int BURST_MAX    = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    ser_bus_arbiter_if.master  bus
);
    localparam int IDW = 3;
    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam int ICW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    // Per-requester views of the flattened packet buses
    logic [14:0]  pAdr_arr   [NREQ];
    logic [127:0] data_arr   [NREQ];
    logic [3:0]   dest_arr   [NREQ];
    logic [3:0]   return_arr [NREQ];
    logic [15:0]  size_arr   [NREQ];

    logic             valid_q,    valid_d;
    logic [IDW-1:0]   grant_q,    grant_d;
    logic [14:0]      pAdr_q,     pAdr_d;
    logic [127:0]     data_q,     data_d;
    logic [3:0]       dest_q,     dest_d;
    logic [3:0]       return_q,   return_d;
    logic             rw_q,       rw_d;
    logic [15:0]      size_q,     size_d;
    logic [0:0]       state_q,    state_d;
    logic [IDW-1:0]   owner_q,    owner_d;
    logic [BCW-1:0]   burst_q,    burst_d;
    logic [ICW-1:0]   idle_q,     idle_d;
    logic [IDW-1:0]   last_q,     last_d;

    logic             accept;
    logic             load_en;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  above_last;
    logic [NREQ-1:0]  eligible_hi;
    logic             hi_found;
    logic [IDW-1:0]   hi_idx;
    logic             lo_found;
    logic [IDW-1:0]   lo_idx;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic             win_valid;

    logic [14:0]      sel_pAdr;
    logic [127:0]     sel_data;
    logic [3:0]       sel_dest;
    logic [3:0]       sel_return;
    logic             sel_rw;
    logic [15:0]      sel_size;
    logic             sel_lock;

    logic [BCW-1:0]   burst_inc;
    logic [ICW-1:0]   idle_inc;

    assign accept  = valid_q & bus.free_block_s & ~bus.full_block_s;
    assign load_en = ~valid_q | accept;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign pAdr_arr[gi]   = bus.req_pAdr[15*gi +: 15];
            assign data_arr[gi]   = bus.req_data[128*gi +: 128];
            assign dest_arr[gi]   = bus.req_dest[4*gi +: 4];
            assign return_arr[gi] = bus.req_return[4*gi +: 4];
            assign size_arr[gi]   = bus.req_size[16*gi +: 16];

            // While locked only the owner competes; everyone else waits untouched.
            assign eligible[gi]   = bus.req_valid[gi] &
                                    ((state_q == ST_UNLOCKED) || (owner_q == IDW'(gi)));
            assign above_last[gi] = (IDW'(gi) > last_q);
            assign bus.req_read[gi] = win_valid & (win_idx == IDW'(gi));
        end
    endgenerate

    assign eligible_hi = eligible & above_last;

    // Round-robin: lowest eligible index above last_grant, else wrap to lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible_hi[i]) begin
                hi_found = 1'b1;
                hi_idx   = IDW'(i);
            end
            if (eligible[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
            end
        end
    end

    assign win_found = lo_found;
    assign win_idx   = hi_found ? hi_idx : lo_idx;
    assign win_valid = load_en & win_found;

    always_comb begin
        sel_pAdr   = '0;
        sel_data   = '0;
        sel_dest   = '0;
        sel_return = '0;
        sel_rw     = 1'b0;
        sel_size   = '0;
        sel_lock   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                sel_pAdr   = pAdr_arr[i];
                sel_data   = data_arr[i];
                sel_dest   = dest_arr[i];
                sel_return = return_arr[i];
                sel_rw     = bus.req_rw[i];
                sel_size   = size_arr[i];
                sel_lock   = bus.req_lock[i];
            end
        end
    end

    assign burst_inc = (burst_q >= BCW'(BURST_MAX)) ? burst_q : burst_q + BCW'(1);
    assign idle_inc  = (idle_q >= ICW'(LOCK_TIMEOUT)) ? idle_q : idle_q + ICW'(1);

    always_comb begin
        valid_d  = valid_q;
        grant_d  = grant_q;
        pAdr_d   = pAdr_q;
        data_d   = data_q;
        dest_d   = dest_q;
        return_d = return_q;
        rw_d     = rw_q;
        size_d   = size_q;
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        idle_d   = idle_q;
        last_d   = last_q;

        if (win_valid) begin
            valid_d  = 1'b1;
            grant_d  = win_idx;
            last_d   = win_idx;
            pAdr_d   = sel_pAdr;
            data_d   = sel_data;
            dest_d   = sel_dest;
            return_d = sel_return;
            rw_d     = sel_rw;
            size_d   = sel_size;

            if (state_q == ST_LOCKED) begin
                burst_d = burst_inc;
                idle_d  = '0;
                // Hitting the burst cap releases the lock; last_grant=owner makes others go first.
                if (!sel_lock || (burst_inc >= BCW'(BURST_MAX))) begin
                    state_d = ST_UNLOCKED;
                end
            end else if (sel_lock) begin
                owner_d = win_idx;
                burst_d = BCW'(1);
                idle_d  = '0;
                state_d = (BURST_MAX > 1) ? ST_LOCKED : ST_UNLOCKED;
            end
        end else if (load_en) begin
            if (accept) begin
                valid_d = 1'b0;
            end
            if (state_q == ST_LOCKED) begin
                idle_d = idle_inc;
                if (idle_inc >= ICW'(LOCK_TIMEOUT)) begin
                    state_d = ST_UNLOCKED;
                    idle_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            grant_q  <= '0;
            pAdr_q   <= '0;
            data_q   <= '0;
            dest_q   <= '0;
            return_q <= '0;
            rw_q     <= 1'b0;
            size_q   <= '0;
            state_q  <= ST_UNLOCKED;
            owner_q  <= '0;
            burst_q  <= '0;
            idle_q   <= '0;
            last_q   <= IDW'(NREQ - 1);
        end else begin
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            pAdr_q   <= pAdr_d;
            data_q   <= data_d;
            dest_q   <= dest_d;
            return_q <= return_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            state_q  <= state_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            idle_q   <= idle_d;
            last_q   <= last_d;
        end
    end

    assign bus.valid_s  = valid_q;
    assign bus.grant_id = grant_q;
    assign bus.pAdr_s   = pAdr_q;
    assign bus.data_s   = data_q;
    assign bus.dest_s   = dest_q;
    assign bus.return_s = return_q;
    assign bus.rw_s     = rw_q;
    assign bus.size_s   = size_q;
endmodule

// File: tb/tb_ser_bus_arbiter.sv
// Bench for ser_bus_arbiter: reset state, a table of directed vectors, multi-cycle
// lock/stall/timeout/reset sequences, and random traffic against a packet-level model.
module tb_ser_bus_arbiter;
    localparam int NREQ = 4;
    localparam int BMAX = 8;
    localparam int TMO  = 16;

    typedef struct packed {
        logic [14:0]  padr;
        logic [127:0] data;
        logic [3:0]   dest;
        logic [3:0]   ret;
        logic         rw;
        logic [15:0]  size;
    } pkt_t;

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [NREQ-1:0] rl;
        logic            free;
        logic            full;
        logic [NREQ-1:0] exp_rd;
        logic            exp_valid;
        logic [2:0]      exp_grant;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] rv = '0;
    logic [NREQ-1:0] rl = '0;
    logic            free = 1'b1;
    logic            full = 1'b0;
    pkt_t            cur_pkt [NREQ];
    pkt_t            dut_out;
    int              n_chk = 0;
    int              n_fail = 0;

    // Packet-level reference state
    bit   m_valid, m_locked, m_accept, m_load;
    int   m_grant, m_last, m_owner, m_burst, m_idle, m_w;
    pkt_t m_out;

    ser_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    ser_bus_arbiter #(.NREQ(NREQ), .BURST_MAX(BMAX), .LOCK_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_valid    = rv;
    assign bus.req_lock     = rl;
    assign bus.free_block_s = free;
    assign bus.full_block_s = full;
    assign dut_out = {bus.pAdr_s, bus.data_s, bus.dest_s, bus.return_s, bus.rw_s, bus.size_s};

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_drv
            assign bus.req_pAdr[15*gi +: 15]    = cur_pkt[gi].padr;
            assign bus.req_data[128*gi +: 128]  = cur_pkt[gi].data;
            assign bus.req_dest[4*gi +: 4]      = cur_pkt[gi].dest;
            assign bus.req_return[4*gi +: 4]    = cur_pkt[gi].ret;
            assign bus.req_rw[gi]               = cur_pkt[gi].rw;
            assign bus.req_size[16*gi +: 16]    = cur_pkt[gi].size;
        end
    endgenerate

    function automatic pkt_t rand_pkt(int i);
        pkt_t p;
        p.padr = 15'($urandom);
        p.data = {$urandom, $urandom, $urandom, $urandom};
        p.dest = 4'(i);
        p.ret  = 4'($urandom);
        p.rw   = 1'($urandom);
        p.size = 16'($urandom);
        return p;
    endfunction

    function automatic int oh_idx(logic [NREQ-1:0] v);
        int idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = (idx == -1) ? i : -2;
        end
        return idx;
    endfunction

    task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_locked = 0; m_grant = 0; m_last = NREQ - 1;
        m_owner = 0; m_burst = 0; m_idle = 0; m_out = '0; m_w = -1;
    endtask

    // Who should be popped this cycle, from the arbitration rules.
    task automatic model_comb();
        int c;
        m_accept = m_valid && free && !full;
        m_load   = !m_valid || m_accept;
        m_w      = -1;
        if (m_load) begin
            if (m_locked) begin
                if (rv[m_owner]) m_w = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (m_w < 0 && rv[c]) m_w = c;
                end
            end
        end
    endtask

    task automatic model_commit();
        if (m_w >= 0) begin
            m_out   = cur_pkt[m_w];
            m_valid = 1;
            m_grant = m_w;
            m_last  = m_w;
            if (m_locked) begin
                m_burst = (m_burst < BMAX) ? m_burst + 1 : BMAX;
                m_idle  = 0;
                if (!rl[m_w] || m_burst >= BMAX) m_locked = 0;
            end else if (rl[m_w] && BMAX > 1) begin
                m_locked = 1; m_owner = m_w; m_burst = 1; m_idle = 0;
            end
            cur_pkt[m_w] = rand_pkt(m_w);
        end else begin
            if (m_accept) m_valid = 0;
            if (m_locked && m_load) begin
                m_idle++;
                if (m_idle >= TMO) begin
                    m_locked = 0;
                    m_idle   = 0;
                end
            end
        end
    endtask

    task automatic sample();
        logic [NREQ-1:0] exp_rd;
        @(negedge clk);
        model_comb();
        exp_rd = '0;
        if (m_w >= 0) exp_rd[m_w] = 1'b1;
        chk("model_req_read", bus.req_read, exp_rd);
        chk("model_valid_s", bus.valid_s, m_valid);
        chk("model_grant_id", bus.grant_id, 3'(m_grant));
        chk("model_fields", dut_out, m_out);
        if (bus.valid_s && free && !full)
            $display("txn: grant=%0d pAdr=%h dest=%h size=%h", bus.grant_id, bus.pAdr_s, bus.dest_s, bus.size_s);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rv = '0; rl = '0; free = 1'b1; full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t         tab [14];
    int           exp4 [12];
    logic [127:0] aa;
    int           stall_err, idle, seen;

    initial begin
        for (int i = 0; i < NREQ; i++) cur_pkt[i] = rand_pkt(i);
        aa = {16{8'hAA}};

        // Reset state
        do_reset();
        sample();
        chk("reset_valid_s", bus.valid_s, 1'b0);
        chk("reset_grant_id", bus.grant_id, 3'd0);
        chk("reset_req_read", bus.req_read, 4'b0000);
        chk("reset_fields", dut_out, 168'd0);
        advance();

        // Single request: pop same cycle, registered next cycle
        cur_pkt[0].padr = 15'h1010;
        rv = 4'b0001;
        sample();
        chk("t1_read_same_cycle", bus.req_read, 4'b0001);
        advance();
        rv = 4'b0000;
        sample();
        chk("t1_valid_s", bus.valid_s, 1'b1);
        chk("t1_pAdr_s", bus.pAdr_s, 15'h1010);
        chk("t1_grant_id", bus.grant_id, 3'd0);
        advance();

        // Table: rotation, stalls, drain, wrap of the round-robin pointer
        tab[0]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd0};
        tab[1]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd0};
        tab[2]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 3'd1};
        tab[3]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd2};
        tab[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 3'd3};
        tab[5]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd0};
        tab[6]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 3'd0};
        tab[7]  = '{4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd0};
        tab[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 3'd1};
        tab[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd1};
        tab[10] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, 3'd1};
        tab[11] = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 3'd2};
        tab[12] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 3'd2};
        tab[13] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd2};
        do_reset();
        for (int r = 0; r < 14; r++) begin
            rv = tab[r].rv; rl = tab[r].rl; free = tab[r].free; full = tab[r].full;
            sample();
            chk($sformatf("tab%0d_req_read", r), bus.req_read, tab[r].exp_rd);
            chk($sformatf("tab%0d_valid_s", r), bus.valid_s, tab[r].exp_valid);
            chk($sformatf("tab%0d_grant_id", r), bus.grant_id, tab[r].exp_grant);
            advance();
        end

        // Long stall holds the output stage
        do_reset();
        cur_pkt[0].data = aa;
        rv = 4'b0011;
        cycle();
        free = 1'b0;
        stall_err = 0;
        for (int k = 0; k < 80; k++) begin
            sample();
            if (bus.valid_s !== 1'b1 || bus.data_s !== aa || bus.req_read !== 4'b0000) stall_err++;
            advance();
        end
        chk("t3_stall_steady", stall_err, 0);
        free = 1'b1;
        sample();
        chk("t3_resume_req_read", bus.req_read, 4'b0010);
        chk("t3_data_until_accept", bus.data_s, aa);
        advance();
        rv = 4'b0000;
        cycle();

        // Locked burst capped at BURST_MAX, then the waiter, then relock
        exp4 = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1};
        do_reset();
        rv = 4'b0110; rl = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            sample();
            chk($sformatf("t4_pop%0d", k), oh_idx(bus.req_read), exp4[k]);
            advance();
        end
        rv = 4'b0000; rl = 4'b0000;
        repeat (3) cycle();

        // Lock timeout after the owner goes idle
        do_reset();
        rv = 4'b0010; rl = 4'b0010;
        sample();
        chk("t5_lock_load", bus.req_read, 4'b0010);
        advance();
        rv = 4'b1000; rl = 4'b0000;
        idle = 0; seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (seen == 0) begin
                sample();
                if (bus.req_read[3]) seen = 1;
                else idle++;
                advance();
            end
        end
        chk("t5_req3_granted", seen, 1);
        chk("t5_idle_cycles", idle, TMO);
        rv = 4'b0000;
        repeat (2) cycle();

        // Reset while a packet is stalled in the output stage
        do_reset();
        rv = 4'b0100;
        cycle();
        free = 1'b0; rv = 4'b0000;
        cycle();
        sample();
        chk("t6_pre_valid", bus.valid_s, 1'b1);
        chk("t6_pre_grant", bus.grant_id, 3'd2);
        advance();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid_s", bus.valid_s, 1'b0);
        chk("t6_async_grant_id", bus.grant_id, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        free = 1'b1; rv = 4'b1111;
        sample();
        chk("t6_first_winner", bus.req_read, 4'b0001);
        advance();
        rv = 4'b0000;
        repeat (2) cycle();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 11) == 0) rv[i] = ~rv[i];
                rl[i] = ($urandom_range(0, 2) != 0);
            end
            free = ($urandom_range(0, 7) != 0);
            full = ($urandom_range(0, 9) == 0);
            cycle();
        end
        rv = '0; rl = '0; free = 1'b1; full = 1'b0;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
